// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the triple-modular-redundancy vote monitor.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_SR   = 2'd1;
    localparam logic [1:0] SRC_JK   = 2'd2;
    localparam logic [1:0] SRC_T    = 2'd3;

    localparam int STREAK_W = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // With three 1-bit inputs, any disagreement isolates exactly one source.
    function automatic logic [1:0] odd_source(input logic sr, input logic jk, input logic t);
        if (sr == jk && jk == t) begin
            return SRC_NONE;
        end else if (jk == t) begin
            return SRC_SR;
        end else if (sr == t) begin
            return SRC_JK;
        end else begin
            return SRC_T;
        end
    endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module tmr_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tmr_vote_monitor.sv
// Majority voter and disagreement monitor for three redundant flip-flop outputs.
// Define TMR_MON_CNT_EN to build the per-source error counters; otherwise err_cnt_* read 0.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int WARMUP       = 2,
    parameter int FAULT_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             q_sr,
    input  logic             q_jk,
    input  logic             q_t,
    output logic             q_vote,
    output logic             mismatch,
    output logic             fault,
    output logic [1:0]       fault_src,
    output logic [CNT_W-1:0] err_cnt_sr,
    output logic [CNT_W-1:0] err_cnt_jk,
    output logic [CNT_W-1:0] err_cnt_t,
    output logic [1:0]       state
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    state_t              state_q, state_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [1:0]          last_src_q, last_src_d;
    logic [1:0]          fault_src_q, fault_src_d;
    logic                q_vote_q, q_vote_d;
    logic                mismatch_q, mismatch_d;
    logic                fault_q, fault_d;

    logic [1:0] odd_src;
    logic       active;
    logic       clr_ok;
    logic       sample_ok;

    assign odd_src   = odd_source(q_sr, q_jk, q_t);
    assign active    = (state_q != ST_WARMUP);
    assign clr_ok    = active & clr;
    assign sample_ok = active & en & ~clr;

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        streak_d    = streak_q;
        last_src_d  = last_src_q;
        fault_src_d = fault_src_q;
        fault_d     = fault_q;
        q_vote_d    = majority3(q_sr, q_jk, q_t);
        mismatch_d  = 1'b0;

        if (state_q == ST_WARMUP) begin
            if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
                state_d = ST_MONITOR;
            end else begin
                warm_cnt_d = warm_cnt_q + WARM_W'(1);
            end
        end

        if (clr_ok) begin
            streak_d    = '0;
            last_src_d  = SRC_NONE;
            fault_d     = 1'b0;
            fault_src_d = SRC_NONE;
            state_d     = ST_MONITOR;
        end else if (sample_ok) begin
            mismatch_d = (odd_src != SRC_NONE);
            last_src_d = odd_src;
            if (odd_src == SRC_NONE) begin
                streak_d = '0;
            end else if (odd_src != last_src_q) begin
                streak_d = STREAK_W'(1);
            end else if (streak_q != '1) begin
                streak_d = streak_q + STREAK_W'(1);
            end
            // fault_src only latches on entry; later mismatches in FAULT leave it alone
            if ((state_q == ST_MONITOR) && (odd_src != SRC_NONE) &&
                (streak_d >= STREAK_W'(FAULT_THRESH))) begin
                fault_d     = 1'b1;
                fault_src_d = odd_src;
                state_d     = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= '0;
            streak_q    <= '0;
            last_src_q  <= SRC_NONE;
            fault_src_q <= SRC_NONE;
            fault_q     <= 1'b0;
            q_vote_q    <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            streak_q    <= streak_d;
            last_src_q  <= last_src_d;
            fault_src_q <= fault_src_d;
            fault_q     <= fault_d;
            q_vote_q    <= q_vote_d;
            mismatch_q  <= mismatch_d;
        end
    end

`ifdef TMR_MON_CNT_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    // Counter index gi tracks source code gi+1 (SR, JK, T).
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        assign cnt_inc[gi] = sample_ok & (odd_src == 2'(gi + 1));
        tmr_sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .clr  (clr_ok),
            .inc  (cnt_inc[gi]),
            .cnt  (cnt_val[gi])
        );
    end

    assign err_cnt_sr = cnt_val[0];
    assign err_cnt_jk = cnt_val[1];
    assign err_cnt_t  = cnt_val[2];
`else
    assign err_cnt_sr = '0;
    assign err_cnt_jk = '0;
    assign err_cnt_t  = '0;
`endif

    assign q_vote    = q_vote_q;
    assign mismatch  = mismatch_q;
    assign fault     = fault_q;
    assign fault_src = fault_src_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Scoreboard bench: stimulus queues expected outputs per edge, a negedge monitor pops and compares.
module tb_tmr_vote_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1 = 1'b0, en1 = 1'b1, clr1 = 1'b0, sr1 = 1'b0, jk1 = 1'b0, t1 = 1'b0;
    logic       vote1, mis1, f1;
    logic [1:0] src1, st1;
    logic [7:0] esr1, ejk1, et1;

    logic       rst2 = 1'b0, en2 = 1'b1, clr2 = 1'b0, sr2 = 1'b0, jk2 = 1'b0, t2 = 1'b0;
    logic       vote2, mis2, f2;
    logic [1:0] src2, st2;
    logic [1:0] esr2, ejk2, et2;

    tmr_vote_monitor dut (
        .clk(clk), .reset(rst1), .en(en1), .clr(clr1),
        .q_sr(sr1), .q_jk(jk1), .q_t(t1),
        .q_vote(vote1), .mismatch(mis1), .fault(f1), .fault_src(src1),
        .err_cnt_sr(esr1), .err_cnt_jk(ejk1), .err_cnt_t(et1), .state(st1)
    );

    tmr_vote_monitor #(.CNT_W(2), .WARMUP(2), .FAULT_THRESH(8)) dut2 (
        .clk(clk), .reset(rst2), .en(en2), .clr(clr2),
        .q_sr(sr2), .q_jk(jk2), .q_t(t2),
        .q_vote(vote2), .mismatch(mis2), .fault(f2), .fault_src(src2),
        .err_cnt_sr(esr2), .err_cnt_jk(ejk2), .err_cnt_t(et2), .state(st2)
    );

    typedef struct {
        int    d;
        int    v, mis, f, src, st, esr, ejk, et;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input string name, input int act, input int exp);
        if (exp < 0) return;
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s.%s got %0d expected %0d", tag, name, act, exp);
    endtask

    // Drive one sample, then queue what the DUT must show after the next edge.
    task automatic step(input int d, input int rst, input int en, input int clr,
                        input int sr, input int jk, input int t,
                        input int v, input int mis, input int f, input int src, input int st,
                        input int esr, input int ejk, input int et, input string tag);
        exp_t e;
        if (d == 0) begin
            rst1 = rst[0]; en1 = en[0]; clr1 = clr[0]; sr1 = sr[0]; jk1 = jk[0]; t1 = t[0];
        end else begin
            rst2 = rst[0]; en2 = en[0]; clr2 = clr[0]; sr2 = sr[0]; jk2 = jk[0]; t2 = t[0];
        end
`ifndef TMR_MON_CNT_EN
        esr = 0; ejk = 0; et = 0;
`endif
        e.d = d; e.v = v; e.mis = mis; e.f = f; e.src = src; e.st = st;
        e.esr = esr; e.ejk = ejk; e.et = et; e.tag = tag;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.d == 0) begin
                    chk(e.tag, "q_vote", int'(vote1), e.v);
                    chk(e.tag, "mismatch", int'(mis1), e.mis);
                    chk(e.tag, "fault", int'(f1), e.f);
                    chk(e.tag, "fault_src", int'(src1), e.src);
                    chk(e.tag, "state", int'(st1), e.st);
                    chk(e.tag, "err_cnt_sr", int'(esr1), e.esr);
                    chk(e.tag, "err_cnt_jk", int'(ejk1), e.ejk);
                    chk(e.tag, "err_cnt_t", int'(et1), e.et);
                end else begin
                    chk(e.tag, "q_vote", int'(vote2), e.v);
                    chk(e.tag, "mismatch", int'(mis2), e.mis);
                    chk(e.tag, "fault", int'(f2), e.f);
                    chk(e.tag, "fault_src", int'(src2), e.src);
                    chk(e.tag, "state", int'(st2), e.st);
                    chk(e.tag, "err_cnt_sr", int'(esr2), e.esr);
                    chk(e.tag, "err_cnt_jk", int'(ejk2), e.ejk);
                    chk(e.tag, "err_cnt_t", int'(et2), e.et);
                end
            end
        end
    end

    initial begin : stimulus
        //   d rst en clr sr jk t   v mis f src st esr ejk et
        repeat (3) step(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, "reset");
        step(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, "warmup0");
        step(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, "warmup1");
        step(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, "idle");
        step(0, 1, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1,  0, 0, 1, "t_odd");
        step(0, 1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 1,  0, 1, 1, "jk1");
        step(0, 1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 1,  0, 2, 1, "jk2");
        step(0, 1, 1, 0, 0, 1, 0,  0, 1, 1, 2, 2,  0, 3, 1, "jk3_fault");
        step(0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 2, 2,  0, 3, 1, "agree_sticky");
        step(0, 1, 1, 1, 1, 0, 0,  0,-1, 0, 0, 1,  0, 0, 0, "clr_in_fault");
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(0, 1, 1, 0, 1, 0, 0,  0, 1, 0, 0, 1,  i/2 + 1, i/2, 0, "alt_sr");
            else
                step(0, 1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 1,  i/2 + 1, i/2 + 1, 0, "alt_jk");
        end
        step(0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1,  3, 3, 0, "en_off");
        step(0, 1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 1,  3, 4, 0, "jk_resume");
        step(0, 1, 1, 0, 0, 1, 0,  0, 1, 1, 2, 2,  3, 5, 0, "jk_fault2");
        step(0, 1, 1, 0, 0, 0, 1,  0, 1, 1, 2, 2,  3, 5, 1, "fault_count");
        step(0, 0, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, "mid_reset");
        step(0, 1, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0,  0, 0, 0, "warm_clr");
        step(0, 1, 1, 0, 1, 1, 0,  1, 0, 0, 0, 1,  0, 0, 0, "warm_end");
        step(0, 1, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1,  0, 0, 1, "post_warm");

        step(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, "d2_reset");
        step(1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, "d2_warm0");
        step(1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, "d2_warm1");
        for (int i = 0; i < 6; i++)
            step(1, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0, 1,  0, 0, (i < 3) ? i + 1 : 3, "d2_sat");
        step(1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, "d2_reset_pulse");
        step(1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, "d2_rewarm");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
